// File: rtl/tetris_pkg.sv
// tetris_pkg
//   Shared definitions for the piece scheduler: piece type codes, LFSR
//   reset seed and tap mask, queue depth and the scheduler FSM encoding.
package tetris_pkg;

  typedef logic [2:0] piece_t;
  typedef logic [1:0] count_t;

  localparam piece_t PIECE_I    = 3'd0;
  localparam piece_t PIECE_J    = 3'd1;
  localparam piece_t PIECE_L    = 3'd2;
  localparam piece_t PIECE_O    = 3'd3;
  localparam piece_t PIECE_S    = 3'd4;
  localparam piece_t PIECE_T    = 3'd5;
  localparam piece_t PIECE_Z    = 3'd6;
  localparam piece_t PIECE_NONE = 3'd7;  // never a real piece

  localparam logic [7:0] LFSR_RESET_SEED = 8'hAC;
  // x^8+x^6+x^5+x^4+1 in a left-shifting Fibonacci register taps b7,b5,b4,b3.
  localparam logic [7:0] LFSR_TAP_MASK   = 8'b1011_1000;

  localparam int     QUEUE_DEPTH = 3;
  localparam count_t COUNT_FULL  = 2'd3;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_FILL = 2'd1,
    ST_FULL = 2'd2
  } sched_state_t;

endpackage

// File: rtl/lfsr8_load.sv
// lfsr8_load
//   Free-running 8-bit Fibonacci LFSR with a synchronous load.
//   A zero seed would lock the register at zero, so it is replaced by 8'h01.
// Ports:
//   clock     - rising-edge clock
//   resetn    - asynchronous active-low reset, loads RESET_SEED
//   load      - load seed instead of shifting this cycle
//   seed      - value to load
//   lfsr_low  - low three bits of the current LFSR state (piece candidate)
module lfsr8_load
  import tetris_pkg::*;
#(
  parameter logic [7:0] RESET_SEED = LFSR_RESET_SEED
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       load,
  input  logic [7:0] seed,
  output logic [2:0] lfsr_low
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;
  logic       feedback;

  always_comb begin
    feedback = ^(lfsr_q & LFSR_TAP_MASK);
    if (load) begin
      lfsr_d = (seed == 8'h00) ? 8'h01 : seed;
    end else begin
      lfsr_d = {lfsr_q[6:0], feedback};
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      lfsr_q <= RESET_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_low = lfsr_q[2:0];

endmodule

// File: rtl/piece_scheduler.sv
// piece_scheduler
//   Generates a stream of Tetris piece types from an LFSR, rejecting the
//   unused code 7 and allowing at most one reroll when a candidate repeats
//   the last pushed piece, and buffers them in a 3-entry FIFO.
// Ports:
//   clock, resetn  - clock and asynchronous active-low reset
//   seed           - LFSR seed, sampled with seed_load
//   seed_load      - reseed the LFSR and flush the queue (wins over req)
//   req            - consume the head piece (ignored when queue is empty)
//   piece/_valid   - head entry of the queue, 0 when invalid
//   preview/_valid - entry behind the head, 0 when invalid
//   count          - queue occupancy 0..3
module piece_scheduler
  import tetris_pkg::*;
#(
  parameter logic [7:0] RESET_SEED = LFSR_RESET_SEED
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] seed,
  input  logic       seed_load,
  input  logic       req,
  output logic [2:0] piece,
  output logic       piece_valid,
  output logic [2:0] preview,
  output logic       preview_valid,
  output logic [1:0] count
);

  sched_state_t state_q, state_d;
  count_t       count_q, count_d;
  piece_t       entry_q [QUEUE_DEPTH];
  piece_t       entry_d [QUEUE_DEPTH];
  piece_t       last_q, last_d;
  logic         reroll_q, reroll_d;

  piece_t       cand;
  logic         pop;
  logic         push_window;
  logic         is_none;
  logic         is_repeat;
  logic         push;
  count_t       tail;

  lfsr8_load #(
    .RESET_SEED (RESET_SEED)
  ) u_lfsr (
    .clock    (clock),
    .resetn   (resetn),
    .load     (seed_load),
    .seed     (seed),
    .lfsr_low (cand)
  );

  // Candidate qualification. The reroll rule is only evaluated when a push
  // could actually happen, so idle cycles never burn the reroll.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    pop         = req && (count_q != 2'd0) && !seed_load;
    push_window = (state_q == ST_FILL) && !seed_load &&
                  ((count_q != COUNT_FULL) || pop);
    is_none     = (cand == PIECE_NONE);
    is_repeat   = (cand == last_q);
    push        = push_window && !is_none && !(is_repeat && !reroll_q);
    // Write slot for the new piece, after the head (if any) has left.
    tail        = count_q - {1'b0, pop};
  end

  // Queue, last-pushed and reroll next-state.
  always_comb begin
    entry_d  = entry_q;
    count_d  = count_q;
    last_d   = last_q;
    reroll_d = reroll_q;

    if (seed_load) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) entry_d[i] = PIECE_I;
      count_d  = 2'd0;
      last_d   = PIECE_NONE;
      reroll_d = 1'b0;
    end else begin
      if (pop) begin
        for (int i = 0; i < QUEUE_DEPTH - 1; i++) entry_d[i] = entry_q[i + 1];
        entry_d[QUEUE_DEPTH - 1] = PIECE_I;
      end
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        if (push && (tail == count_t'(i))) entry_d[i] = cand;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};

      if (push) begin
        last_d   = cand;
        reroll_d = 1'b0;
      end else if (push_window && !is_none && is_repeat) begin
        reroll_d = 1'b1;
      end
    end
  end

  // FSM next-state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT: state_d = ST_FILL;
      ST_FILL: if (push && !pop && (count_q == 2'd2)) state_d = ST_FULL;
      ST_FULL: if (pop) state_d = ST_FILL;
      default: state_d = ST_INIT;
    endcase
    if (seed_load) state_d = ST_INIT;
  end

  // FSM state register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Queue storage. NOTE: the three entries are reset explicitly; at this
  // size they are plain flops, and a defined reset value keeps the outputs
  // deterministic for the bench and downstream logic.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) entry_q[i] <= PIECE_I;
      count_q  <= 2'd0;
      last_q   <= PIECE_NONE;
      reroll_q <= 1'b0;
    end else begin
      entry_q  <= entry_d;
      count_q  <= count_d;
      last_q   <= last_d;
      reroll_q <= reroll_d;
    end
  end

  // Outputs are masked to zero when the corresponding entry is invalid.
  always_comb begin
    piece_valid   = (count_q != 2'd0);
    preview_valid = (count_q >= 2'd2);
    piece         = piece_valid   ? entry_q[0] : PIECE_I;
    preview       = preview_valid ? entry_q[1] : PIECE_I;
    count         = count_q;
  end

endmodule

// File: tb/tb_piece_scheduler.sv
// tb_piece_scheduler
//   Randomized bench for piece_scheduler. A behavioural model (integer LFSR,
//   a queue of pieces and the acceptance rules) predicts every output each
//   cycle; scenario tasks add targeted checks on top.
module tb_piece_scheduler;

  logic       clock = 1'b0;
  logic       resetn;
  logic [7:0] seed;
  logic       seed_load;
  logic       req;
  logic [2:0] piece;
  logic       piece_valid;
  logic [2:0] preview;
  logic       preview_valid;
  logic [1:0] count;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int m_lfsr;
  int m_q[$];    // queued piece codes, head first
  bit m_qf[$];   // per entry: pushed right after a consumed reroll
  int m_last;
  bit m_reroll;
  bit m_started; // past the post-reset / post-seed idle cycle
  bit m_full;    // filling paused until a pop

  int rec[$];
  int rec_first[$];
  bit pat[150];

  piece_scheduler #(
    .RESET_SEED (8'hAC)
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .seed          (seed),
    .seed_load     (seed_load),
    .req           (req),
    .piece         (piece),
    .piece_valid   (piece_valid),
    .preview       (preview),
    .preview_valid (preview_valid),
    .count         (count)
  );

  always #5 clock = ~clock;

  function automatic logic [9:0] exp_vec();
    logic [2:0] p  = 3'd0;
    logic [2:0] pr = 3'd0;
    int n = m_q.size();
    if (n > 0) p  = 3'(m_q[0]);
    if (n > 1) pr = 3'(m_q[1]);
    return {n > 0, p, n > 1, pr, 2'(n)};
  endfunction

  function automatic logic [9:0] dut_vec();
    return {piece_valid, piece, preview_valid, preview, count};
  endfunction

  task automatic model_reset();
    m_lfsr = 8'hAC;
    m_q.delete();
    m_qf.delete();
    m_last    = 7;
    m_reroll  = 1'b0;
    m_started = 1'b0;
    m_full    = 1'b0;
  endtask

  // One clock edge of the specified behaviour, using the inputs present at it.
  task automatic model_step();
    int cand, fb;
    bit pop, may_push, push, after_reroll;
    cand = m_lfsr % 8;
    fb   = ((m_lfsr / 128) + (m_lfsr / 32) + (m_lfsr / 16) + (m_lfsr / 8)) % 2;
    if (seed_load) begin
      m_lfsr = (seed == 8'h00) ? 1 : int'(seed);
      m_q.delete();
      m_qf.delete();
      m_last    = 7;
      m_reroll  = 1'b0;
      m_started = 1'b0;
      m_full    = 1'b0;
      return;
    end
    pop          = req && (m_q.size() > 0);
    may_push     = m_started && !m_full && (m_q.size() < 3 || pop);
    push         = 1'b0;
    after_reroll = m_reroll;
    if (may_push && cand != 7) begin
      if (cand == m_last && !m_reroll) m_reroll = 1'b1;
      else push = 1'b1;
    end
    if (pop) begin
      void'(m_q.pop_front());
      void'(m_qf.pop_front());
      m_full = 1'b0;
    end
    if (push) begin
      m_q.push_back(cand);
      m_qf.push_back(after_reroll);
      m_last   = cand;
      m_reroll = 1'b0;
      if (!pop && m_q.size() == 3) m_full = 1'b1;
    end
    m_started = 1'b1;
    m_lfsr    = ((m_lfsr * 2) % 256) + fb;
  endtask

  task automatic step();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b1; seed = 8'h00; seed_load = 1'b0; req = 1'b0;
    #1 resetn = 1'b0;
    #2;
    model_reset();
    total++;
    if (dut_vec() !== 10'd0)
      $display("FAIL reset_outputs: got %h want 000", dut_vec());
    if (dut_vec() !== 10'd0) bad++;
    #9 resetn = 1'b1;  // released between edges
    total++;
    if (dut.u_lfsr.lfsr_q !== 8'hAC) begin
      bad++;
      $display("FAIL reset_lfsr: got %h want ac", dut.u_lfsr.lfsr_q);
    end
    step();
    total++;
    if (count !== 2'd0 || piece_valid !== 1'b0) begin
      bad++;
      $display("FAIL first_edge_no_push: count=%0d valid=%b want 0/0", count, piece_valid);
    end
  endtask

  task automatic test_fill();
    int first = -1;
    req = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      step();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL fill_cycle %0d: got %h want %h", c, dut_vec(), exp_vec());
      end
      if (first < 0 && piece_valid === 1'b1) first = c + 2;
    end
    total++;
    if (first < 0 || first > 20) begin
      bad++;
      $display("FAIL fill_latency: got %0d cycles want <=20", first);
    end
    total++;
    if (count !== 2'd3) begin
      bad++;
      $display("FAIL fill_count: got %0d want 3", count);
    end
  endtask

  task automatic test_pop_random();
    int exp_head, prev, cur;
    bit have_prev = 1'b0;
    bit flag;
    exp_head = m_q[1];
    req = 1'b1;
    step();
    req = 1'b0;
    total++;
    if (piece !== 3'(exp_head) || !(count === 2'd2 || count === 2'd3)) begin
      bad++;
      $display("FAIL single_pop: piece=%0d count=%0d want piece=%0d count 2..3",
               piece, count, exp_head);
    end
    for (int c = 0; c < 10000; c++) begin
      req = ($urandom_range(0, 2) == 0);
      if (req && m_q.size() > 0) begin
        cur  = int'(piece);
        flag = m_qf[0];
        total++;
        if (have_prev && cur == prev && !flag) begin
          bad++;
          $display("FAIL repeat_rule %0d: piece %0d repeated without reroll", c, cur);
        end
        prev      = cur;
        have_prev = 1'b1;
      end
      step();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL random_cycle %0d: got %h want %h", c, dut_vec(), exp_vec());
      end
    end
    req = 1'b0;
  endtask

  task automatic test_seed_zero();
    seed = 8'h00; seed_load = 1'b1; req = 1'b1;
    step();
    seed_load = 1'b0; req = 1'b0;
    total++;
    if (dut.u_lfsr.lfsr_q !== 8'h01 || count !== 2'd0 || piece_valid !== 1'b0) begin
      bad++;
      $display("FAIL seed_zero: lfsr=%h count=%0d valid=%b want 01/0/0",
               dut.u_lfsr.lfsr_q, count, piece_valid);
    end
    step();
    total++;
    if (count !== 2'd0 || dut_vec() !== exp_vec()) begin
      bad++;
      $display("FAIL init_no_push: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic fill_to_full(input string tag);
    int n = 0;
    req = 1'b0;
    while (m_q.size() < 3 && n < 200) begin
      step();
      n++;
    end
    total++;
    if (count !== 2'd3) begin
      bad++;
      $display("FAIL %s_fill_timeout: count=%0d want 3", tag, count);
    end
  endtask

  task automatic test_seed_req();
    logic [7:0] s = 8'($urandom_range(1, 255));
    for (int i = 0; i < 150; i++) pat[i] = ($urandom_range(0, 1) == 1);
    for (int r = 0; r < 2; r++) begin
      fill_to_full("seed_req");
      seed = s; seed_load = 1'b1; req = 1'b1;
      step();
      seed_load = 1'b0; req = 1'b0;
      total++;
      if (count !== 2'd0 || piece_valid !== 1'b0) begin
        bad++;
        $display("FAIL seed_req_flush: count=%0d valid=%b want 0/0", count, piece_valid);
      end
      rec.delete();
      for (int c = 0; c < 150; c++) begin
        req = pat[c];
        if (req && piece_valid === 1'b1) rec.push_back(int'(piece));
        step();
        total++;
        if (dut_vec() !== exp_vec()) begin
          bad++;
          $display("FAIL reseed_cycle %0d: got %h want %h", c, dut_vec(), exp_vec());
        end
      end
      if (r == 0) rec_first = rec;
    end
    req = 1'b0;
    begin
      bit same = (rec.size() == rec_first.size()) && (rec.size() > 0);
      for (int i = 0; i < rec.size() && i < rec_first.size(); i++)
        if (rec[i] != rec_first[i]) same = 1'b0;
      total++;
      if (!same) begin
        bad++;
        $display("FAIL seed_repeatable: run sizes %0d/%0d differ or content differs",
                 rec_first.size(), rec.size());
      end
    end
  endtask

  task automatic test_req_hold();
    int zeros = 0, ones = 0;
    req = 1'b1;
    for (int c = 0; c < 300; c++) begin
      step();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL req_hold_cycle %0d: got %h want %h", c, dut_vec(), exp_vec());
      end
      if (piece_valid === 1'b1) ones++;
      else zeros++;
    end
    req = 1'b0;
    total++;
    if (ones == 0) begin
      bad++;
      $display("FAIL req_hold_valid: valid never high over %0d cycles", zeros);
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    seed = 8'($urandom_range(0, 255)); seed_load = 1'b1;
    step();
    seed_load = 1'b0;
    while (m_q.size() != 2 && n < 100) begin
      step();
      n++;
    end
    total++;
    if (count !== 2'd2) begin
      bad++;
      $display("FAIL async_setup: count=%0d want 2", count);
    end
    resetn = 1'b0;
    #1;
    total++;
    if (dut_vec() !== 10'd0 || dut.u_lfsr.lfsr_q !== 8'hAC) begin
      bad++;
      $display("FAIL async_reset: got %h lfsr=%h want 000/ac", dut_vec(), dut.u_lfsr.lfsr_q);
    end
    model_reset();
    #1 resetn = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL post_reset_cycle %0d: got %h want %h", c, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_pop_random();
    test_seed_zero();
    test_seed_req();
    test_req_hold();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
